scan_controller: RTL and testbench
==================================

SCAN_CONTROLLER -- requirements
Module: scan_controller

Interface
REQ-001 Parameter GUARD_CYCLES, default 2: blanked cycles at the start of every digit slot (>=1).
REQ-002 Parameter STEP, default 4: cycles per brightness step; slot length = GUARD_CYCLES + 8*STEP (default 34), frame = 4 slots (default 136).
REQ-003 CLK  in  1  single clock; every register uses its rising edge.
REQ-004 RST  in  1  reset, synchronous and active-high.
REQ-005 EN  in  1  display enable; low forces blanking, counters keep running.
REQ-006 LZS  in  1  leading-zero suppression enable.
REQ-007 BRIGHT  in  3  brightness level 0..7, lit time = (BRIGHT+1)*STEP cycles per slot.
REQ-008 D0, D1, D2, D3  in  4 each  BCD digits; D0 = seconds ones ... D3 = minutes tens.
REQ-009 DIG_SEL  out  2  index of the digit slot currently scanned.
REQ-010 DIG_EN  out  4  one-hot digit drive, bit n = digit n; all zero when not lit.
REQ-011 BCD  out  4  shadow copy of the digit at DIG_SEL, fed to the BCD-to-segment decoder.
REQ-012 BLANK  out  1  high whenever DIG_EN is all zero.
REQ-013 FRAME  out  1  one-cycle pulse on the last cycle of slot 3.

Function
REQ-014 Slot counter CNT counts 0..GUARD_CYCLES+8*STEP-1 and wraps; on wrap, IDX (= DIG_SEL) increments 0->1->2->3->0.
REQ-015 Shadow registers S0..S3 and BRIGHT_S load D0..D3 and BRIGHT only on the edge where CNT wraps with IDX=3 (frame boundary); mid-frame input changes are not displayed.
REQ-016 EN is registered (EN_R); blanking takes effect one cycle after EN changes.
REQ-017 LIT = EN_R and not SUPP(IDX) and CNT >= GUARD_CYCLES and CNT < GUARD_CYCLES + (BRIGHT_S+1)*STEP.
REQ-018 SUPP(3) = LZS and S3==0; SUPP(2) = SUPP(3) and S2==0; SUPP(1) = SUPP(0) = 0.
REQ-019 DIG_EN = one-hot(IDX) when LIT, else 4'b0000; BLANK = not LIT.
REQ-020 BCD = S[IDX] in every cycle, lit or not; values 10..15 pass through unmodified.
REQ-021 FRAME = 1 exactly when IDX=3 and CNT = last slot count.
REQ-022 All outputs are functions of registered state only; no combinational path from any input to any output.
REQ-023 BRIGHT=7 lights the full post-guard slot; the guard interval always separates consecutive digits (no two DIG_EN bits ever high, no digit lit in cycle 0 of a slot).

Reset
REQ-024 While RST=1 at a clock edge: CNT=0, IDX=0, S0..S3=0, BRIGHT_S=0, EN_R=0.
REQ-025 Resulting outputs: DIG_SEL=0, DIG_EN=0000, BLANK=1, BCD=0, FRAME=0.
REQ-026 RST asserted mid-slot or mid-frame overrides all counting and loads in that cycle; the first frame after reset displays shadow zeros, new inputs appear from the second frame.

Verification
REQ-027 Defaults, RST then EN=1, D=3/2/1/0, BRIGHT=7, LZS=0 -> frame 1 shows 0 on all digits; from frame 2 each slot: CNT 0..1 blank, CNT 2..33 DIG_EN one-hot with BCD=D[IDX]; FRAME pulse every 136 cycles.
REQ-028 BRIGHT=0 loaded at frame boundary -> each digit lit exactly 4 cycles (CNT 2..5), blank CNT 6..33; change to BRIGHT=3 mid-frame -> no effect until next frame, then lit CNT 2..17.
REQ-029 LZS=1, D3=0, D2=0, D1=5, D0=9 -> slots 3 and 2 fully blank, slots 1 and 0 lit; D2=7 -> only slot 3 blank; LZS=0 -> all lit.
REQ-030 EN dropped at CNT=10 of slot 1 -> DIG_EN=0 from next cycle, DIG_SEL/CNT/FRAME timing unchanged; EN restored -> lit one cycle later within current slot window.
REQ-031 RST pulsed for one cycle at IDX=2, CNT=20 -> next cycle DIG_SEL=0, CNT=0, BLANK=1, BCD=0; scanning restarts from slot 0.

Source files
------------

// File: rtl/scan_controller.sv
// -----------------------------------------------------------------------------
// scan_controller
//
// Time-multiplexed driver for a 4-digit MM:SS display.
//
// Each digit owns a slot of GUARD_CYCLES + 8*STEP clock cycles, and the four
// slots make one frame. Every slot starts with a blanked guard interval,
// followed by a lit window of (brightness+1)*STEP cycles. After the lit
// window the digit stays dark until the slot ends.
//
// The digit values and the brightness are captured into shadow registers
// only at the frame boundary. This way one frame never shows a mix of old
// and new digits.
//
// Every output is decoded from registered state only. EN and LZS are
// therefore registered before use.
//
// Parameters
//   GUARD_CYCLES  blanked cycles at the start of every slot (>= 1)
//   STEP          cycles per brightness step
//
// Ports
//   CLK      in   clock, rising edge
//   RST      in   synchronous active-high reset
//   EN       in   display enable (low blanks the display, counters keep going)
//   LZS      in   leading-zero suppression for the two minutes digits
//   BRIGHT   in   [2:0] brightness level 0..7
//   D0..D3   in   [3:0] BCD digits, D0 = seconds ones ... D3 = minutes tens
//   DIG_SEL  out  [1:0] index of the slot being scanned
//   DIG_EN   out  [3:0] one-hot digit drive, zero while dark
//   BCD      out  [3:0] shadowed digit value for the current slot
//   BLANK    out  high whenever DIG_EN is all zero
//   FRAME    out  one-cycle pulse on the last cycle of slot 3
// -----------------------------------------------------------------------------
module scan_controller #(
    parameter int GUARD_CYCLES = 2,
    parameter int STEP         = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic       LZS,
    input  logic [2:0] BRIGHT,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    input  logic [3:0] D2,
    input  logic [3:0] D3,
    output logic [1:0] DIG_SEL,
    output logic [3:0] DIG_EN,
    output logic [3:0] BCD,
    output logic       BLANK,
    output logic       FRAME
);

    localparam int SLOT_LEN = GUARD_CYCLES + 8 * STEP;
    // SLOT_LEN is at least 9, so CW is always at least 4.
    localparam int CW       = $clog2(SLOT_LEN);

    // The end of the lit window can equal SLOT_LEN. That value does not
    // always fit in CW bits, so the window arithmetic uses one extra bit.
    typedef logic [CW:0] win_t;

    localparam logic [CW-1:0] CNT_LAST  = CW'(SLOT_LEN - 1);
    localparam win_t          GUARD_EXT = win_t'(GUARD_CYCLES);
    localparam win_t          STEP_EXT  = win_t'(STEP);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [1:0]      idx_q,      idx_d;
    logic [3:0][3:0] shadow_q,   shadow_d;   // [n] holds digit n
    logic [2:0]      bright_s_q, bright_s_d;
    logic            en_r_q,     en_r_d;
    logic            lzs_r_q,    lzs_r_d;

    // ------------------------------------------------------------------
    // Slot / digit counters
    // ------------------------------------------------------------------
    logic cnt_wrap;
    logic frame_end;

    always_comb begin
        cnt_wrap  = (cnt_q == CNT_LAST);
        frame_end = cnt_wrap && (idx_q == 2'd3);

        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_wrap) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;   // wraps 3 -> 0 naturally
        end
    end

    // ------------------------------------------------------------------
    // Shadow registers: load only on the edge that closes slot 3
    // ------------------------------------------------------------------
    always_comb begin
        shadow_d   = shadow_q;
        bright_s_d = bright_s_q;
        if (frame_end) begin
            shadow_d   = {D3, D2, D1, D0};
            bright_s_d = BRIGHT;
        end
    end

    // ------------------------------------------------------------------
    // Input retiming. Blanking from EN lands one cycle later. LZS is
    // registered too, so that no input reaches an output combinationally.
    // ------------------------------------------------------------------
    always_comb begin
        en_r_d  = EN;
        lzs_r_d = LZS;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            shadow_q   <= '0;
            bright_s_q <= '0;
            en_r_q     <= 1'b0;
            lzs_r_q    <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            bright_s_q <= bright_s_d;
            en_r_q     <= en_r_d;
            lzs_r_q    <= lzs_r_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered state only)
    // ------------------------------------------------------------------
    logic supp3;
    logic supp2;
    logic supp_cur;
    win_t cnt_ext;
    win_t lit_end;
    logic in_window;
    logic lit;

    always_comb begin
        // Minutes-tens is suppressed when it is zero. Minutes-ones is
        // suppressed only when minutes-tens is suppressed as well.
        // The seconds digits are never suppressed.
        supp3 = lzs_r_q && (shadow_q[3] == 4'd0);
        supp2 = supp3 && (shadow_q[2] == 4'd0);

        supp_cur = 1'b0;
        case (idx_q)
            2'd3:    supp_cur = supp3;
            2'd2:    supp_cur = supp2;
            default: supp_cur = 1'b0;
        endcase

        // Lit window is [GUARD, GUARD + (BRIGHT_S+1)*STEP). At brightness 7
        // it reaches the end of the slot. The guard interval always
        // separates adjacent digits because it sits at the start of every
        // slot.
        cnt_ext   = win_t'(cnt_q);
        lit_end   = GUARD_EXT + (win_t'(bright_s_q) + win_t'(1)) * STEP_EXT;
        in_window = (cnt_ext >= GUARD_EXT) && (cnt_ext < lit_end);

        lit = en_r_q && !supp_cur && in_window;

        DIG_SEL = idx_q;
        DIG_EN  = lit ? (4'b0001 << idx_q) : 4'b0000;
        BLANK   = !lit;
        BCD     = shadow_q[idx_q];   // passed through even when dark or > 9
        FRAME   = frame_end;
    end

endmodule

// File: tb/tb_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_scan_controller
//
// Directed bench for scan_controller with its default parameters:
// GUARD_CYCLES = 2 and STEP = 4, so a slot is 34 cycles and a frame is 136.
//
// Each frame is walked cycle by cycle. The expected values come from
// hand-chosen constants passed to each frame:
//   - the last lit slot count (33, 5 or 17 for brightness 7, 0 or 3),
//   - the digits shown,
//   - which slots are suppressed,
//   - the frame positions where EN drops and returns.
// Inputs change just after a rising edge. Outputs are sampled 1 ns after it.
// -----------------------------------------------------------------------------
module tb_scan_controller;

    localparam int SLOT  = 34;
    localparam int FRM   = 136;
    localparam int GUARD = 2;

    logic       clk;
    logic       rst;
    logic       en;
    logic       lzs;
    logic [2:0] bright;
    logic [3:0] d0, d1, d2, d3;
    logic [1:0] dig_sel;
    logic [3:0] dig_en;
    logic [3:0] bcd;
    logic       blank;
    logic       frame;

    int n_checks = 0;
    int n_errors = 0;

    scan_controller dut (
        .CLK     (clk),
        .RST     (rst),
        .EN      (en),
        .LZS     (lzs),
        .BRIGHT  (bright),
        .D0      (d0),
        .D1      (d1),
        .D2      (d2),
        .D3      (d3),
        .DIG_SEL (dig_sel),
        .DIG_EN  (dig_en),
        .BCD     (bcd),
        .BLANK   (blank),
        .FRAME   (frame)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dig_sel"}, 32'(dig_sel), 32'd0);
        check({tag, " dig_en"},  32'(dig_en),  32'd0);
        check({tag, " blank"},   32'(blank),   32'd1);
        check({tag, " bcd"},     32'(bcd),     32'd0);
        check({tag, " frame"},   32'(frame),   32'd0);
    endtask

    // Walk n_cyc cycles of a frame. The walk must start at slot 0, count 0.
    //   lit_hi     last slot count that is lit
    //   digs       {d3,d2,d1,d0} expected on BCD
    //   supp       slots expected to be fully dark
    //   chg_pos    frame position after which BRIGHT becomes chg_bright
    //   off/on     frame positions after which EN is dropped / restored
    task automatic run_frame(input string tag, input int n_cyc, input int lit_hi,
                             input logic [15:0] digs, input logic [3:0] supp,
                             input int chg_pos, input logic [2:0] chg_bright,
                             input int off_pos, input int on_pos);
        int         idx;
        int         cnt;
        logic       exp_lit;
        logic [3:0] exp_en;
        logic       exp_frame;
        for (int p = 0; p < n_cyc; p++) begin
            idx       = p / SLOT;
            cnt       = p % SLOT;
            exp_lit   = (cnt >= GUARD) && (cnt <= lit_hi) && !supp[idx]
                        && !((p > off_pos) && (p <= on_pos));
            exp_en    = exp_lit ? (4'b0001 << idx) : 4'b0000;
            exp_frame = (idx == 3) && (cnt == SLOT - 1);
            check($sformatf("%s p%0d dig_sel", tag, p), 32'(dig_sel), 32'(idx));
            check($sformatf("%s p%0d dig_en",  tag, p), 32'(dig_en),  32'(exp_en));
            check($sformatf("%s p%0d blank",   tag, p), 32'(blank),   32'(!exp_lit));
            check($sformatf("%s p%0d bcd",     tag, p), 32'(bcd),     32'(digs[idx*4 +: 4]));
            check($sformatf("%s p%0d frame",   tag, p), 32'(frame),   32'(exp_frame));
            if (p == chg_pos) bright = chg_bright;
            if (p == off_pos) en = 1'b0;
            if (p == on_pos)  en = 1'b1;
            tick();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        en     = 1'b1;
        lzs    = 1'b0;
        bright = 3'd7;
        d0 = 4'd3; d1 = 4'd2; d2 = 4'd1; d3 = 4'd0;
        tick();
        tick();
        check_reset_outputs("reset");

        // Frame 1 shows the reset shadow: zeros at brightness 0.
        rst = 1'b0;
        run_frame("f1_zero", FRM, 5, 16'h0000, 4'b0000, -1, 3'd0, -1, -1);

        // Frame 2: full brightness. BRIGHT=0 is applied now, which is
        // mid-frame, so it is only picked up at the end of frame 2.
        bright = 3'd0;
        run_frame("f2_full", FRM, 33, 16'h0123, 4'b0000, -1, 3'd0, -1, -1);

        // Frame 3: brightness 0. BRIGHT=3 arrives at slot 1, count 10.
        run_frame("f3_b0", FRM, 5, 16'h0123, 4'b0000, SLOT + 10, 3'd3, -1, -1);

        // Frame 4: brightness 3. New digits 0/0/5/9 are staged for frame 5.
        d3 = 4'd0; d2 = 4'd0; d1 = 4'd5; d0 = 4'd9;
        run_frame("f4_b3", FRM, 17, 16'h0123, 4'b0000, -1, 3'd0, -1, -1);

        // Frame 5: LZS hides both minutes digits. D2=7 is staged for frame 6.
        lzs = 1'b1;
        d2  = 4'd7;
        run_frame("f5_lzs2", FRM, 17, 16'h0059, 4'b1100, -1, 3'd0, -1, -1);

        // Frame 6: only the minutes-tens digit is hidden.
        run_frame("f6_lzs1", FRM, 17, 16'h0759, 4'b1000, -1, 3'd0, -1, -1);

        // Frame 7: LZS off. EN drops at slot 1 count 10 and returns at count 14.
        lzs = 1'b0;
        run_frame("f7_en", FRM, 17, 16'h0759, 4'b0000, -1, 3'd0, SLOT + 10, SLOT + 14);

        // Frame 8 runs up to slot 2 count 20. A one-cycle reset is applied there.
        run_frame("f8_part", 2 * SLOT + 20, 17, 16'h0759, 4'b0000, -1, 3'd0, -1, -1);
        check("pre_rst bcd", 32'(bcd), 32'd7);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        rst = 1'b0;

        // After the reset the shadow is zero again. New inputs appear a frame later.
        run_frame("f9_zero", FRM, 5, 16'h0000, 4'b0000, -1, 3'd0, -1, -1);
        run_frame("f10_new", FRM, 17, 16'h0759, 4'b0000, -1, 3'd0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
